// File: rtl/operand_pool_pkg.sv
// Shared types and constants for the operand pool sequencer.
package operand_pool_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // Galois feedback mask for x^8+x^6+x^5+x^4+1 (right-shifting form)
  localparam logic [7:0] LFSR_TAPS     = 8'hB8;
  localparam logic [7:0] LFSR_SEED_DEF = 8'hA5;

endpackage

// File: rtl/pool_lfsr.sv
// 8-bit Galois LFSR with synchronous seed load and step enable.
module pool_lfsr
  import operand_pool_pkg::*;
#(
  parameter logic [7:0] SEED = LFSR_SEED_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       step,
  output logic [7:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       q <= SEED;
    else if (load) q <= SEED;
    else if (step) q <= {1'b0, q[7:1]} ^ (q[0] ? LFSR_TAPS : 8'h00);
  end

endmodule

// File: rtl/operand_pool_sequencer.sv
// Operand-pair scheduler: loads a pool, then issues (pool[i], pool[(i+1) mod count]).
// Random index selection is compiled in only with OPERAND_POOL_RANDOM_EN defined.
module operand_pool_sequencer
  import operand_pool_pkg::*;
#(
  parameter int         WIDTH     = 8,
  parameter int         DEPTH     = 16,
  parameter logic [7:0] LFSR_SEED = LFSR_SEED_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_valid,
  input  logic [WIDTH-1:0]         wr_data,
  output logic                     wr_ready,
  input  logic                     clear,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     mode,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         A,
  output logic [WIDTH-1:0]         B,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     busy
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;

  logic [WIDTH-1:0] pool [DEPTH];
  state_e           state;
  logic [IW-1:0]    idx;
  logic [IW-1:0]    sel, sel_nxt;
  logic             sel_ok;
  logic             wr_fire, slot_free;

  assign wr_ready  = !clear && (count < CW'(DEPTH));
  assign wr_fire   = wr_valid && wr_ready;
  assign slot_free = !out_valid || out_ready;

  // Storage is intentionally not reset; count bounds every read.
  always_ff @(posedge clk) begin
    if (wr_fire) pool[count[IW-1:0]] <= wr_data;
  end

`ifdef OPERAND_POOL_RANDOM_EN
  logic [7:0] lfsr_q;
  logic       unused_lfsr;

  pool_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .load (clear),
    .step (state == RUN && !clear),
    .q    (lfsr_q)
  );
  assign unused_lfsr = ^lfsr_q;

  always_comb begin
    sel    = mode ? lfsr_q[IW-1:0] : idx;
    sel_ok = (CW'(sel) < count);
  end
`else
  logic unused_cfg;
  assign unused_cfg = mode ^ (^LFSR_SEED);

  always_comb begin
    sel    = idx;
    sel_ok = 1'b1;
  end
`endif

  // Cyclic successor within the loaded range
  always_comb begin
    sel_nxt = sel + IW'(1);
    if (CW'(sel) + CW'(1) == count) sel_nxt = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      count     <= '0;
      idx       <= '0;
      A         <= '0;
      B         <= '0;
      out_valid <= 1'b0;
    end else if (clear) begin
      state     <= IDLE;
      busy      <= 1'b0;
      count     <= '0;
      idx       <= '0;
      out_valid <= 1'b0;
    end else begin
      if (wr_fire) count <= count + CW'(1);
      case (state)
        IDLE: begin
          out_valid <= 1'b0;
          if (start && count != '0) begin
            state <= RUN;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          if (stop) begin
            // a pair accepted this cycle leaves nothing pending for DRAIN
            state <= DRAIN;
            if (slot_free) out_valid <= 1'b0;
          end else if (slot_free) begin
            if (sel_ok) begin
              A         <= pool[sel];
              B         <= pool[sel_nxt];
              out_valid <= 1'b1;
              idx       <= sel_nxt;
            end else begin
              out_valid <= 1'b0;
            end
          end
        end
        DRAIN: begin
          if (slot_free) begin
            out_valid <= 1'b0;
            state     <= IDLE;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_operand_pool_sequencer.sv
// Self-checking bench for operand_pool_sequencer (DEPTH=8); random-mode checks under OPERAND_POOL_RANDOM_EN.
module tb_operand_pool_sequencer;

  localparam int WIDTH = 8;
  localparam int DEPTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             wr_valid, clear, start, stop, mode, out_ready;
  logic [WIDTH-1:0] wr_data;
  logic             wr_ready, out_valid, busy;
  logic [WIDTH-1:0] A, B;
  logic [3:0]       count;

  int checks = 0;
  int errors = 0;

  operand_pool_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .clear(clear), .start(start), .stop(stop), .mode(mode), .out_valid(out_valid),
    .out_ready(out_ready), .A(A), .B(B), .count(count), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string      nm;
    logic       wv;
    logic [7:0] wd;
    logic       st, sp, rdy;
    logic       ev;
    logic [7:0] ea, eb;
    logic [3:0] ec;
    logic       ebusy;
  } vec_t;

  function automatic vec_t mk(string nm, logic wv, logic [7:0] wd, logic st, logic sp,
                              logic rdy, logic ev, logic [7:0] ea, logic [7:0] eb,
                              logic [3:0] ec, logic ebusy);
    vec_t v;
    v.nm = nm; v.wv = wv; v.wd = wd; v.st = st; v.sp = sp; v.rdy = rdy;
    v.ev = ev; v.ea = ea; v.eb = eb; v.ec = ec; v.ebusy = ebusy;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1; step(); clear = 1'b0;
  endtask

  task automatic wr(logic [7:0] v);
    wr_valid = 1'b1; wr_data = v; step(); wr_valid = 1'b0;
  endtask

  vec_t       tbl[$];
  logic [7:0] mp[$];
  logic       m_ov, m_run;
  logic [7:0] m_a, m_b;
  int         m_i;

  initial begin
    rst = 1'b1; wr_valid = 0; wr_data = 0; clear = 0; start = 0; stop = 0; mode = 0; out_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_A", A, 0);
    chk("rst_B", B, 0);
    chk("rst_count", count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wr_ready", wr_ready, 1);
    rst = 1'b0;

    // ---- directed table: 10,20,30 sequential ----
    tbl.push_back(mk("ld10",  1, 10, 0, 0, 1, 0,  0,  0, 1, 0));
    tbl.push_back(mk("ld20",  1, 20, 0, 0, 1, 0,  0,  0, 2, 0));
    tbl.push_back(mk("ld30",  1, 30, 0, 0, 1, 0,  0,  0, 3, 0));
    tbl.push_back(mk("start", 0,  0, 1, 0, 1, 0,  0,  0, 3, 1));
    tbl.push_back(mk("p0",    0,  0, 0, 0, 1, 1, 10, 20, 3, 1));
    tbl.push_back(mk("p1",    0,  0, 0, 0, 1, 1, 20, 30, 3, 1));
    tbl.push_back(mk("p2",    0,  0, 0, 0, 1, 1, 30, 10, 3, 1));
    tbl.push_back(mk("p3",    0,  0, 0, 0, 1, 1, 10, 20, 3, 1));
    tbl.push_back(mk("stop",  0,  0, 0, 1, 1, 0, 10, 20, 3, 1));
    tbl.push_back(mk("idle",  0,  0, 0, 0, 1, 0, 10, 20, 3, 0));
    foreach (tbl[k]) begin
      wr_valid = tbl[k].wv; wr_data = tbl[k].wd; start = tbl[k].st;
      stop = tbl[k].sp; out_ready = tbl[k].rdy;
      step();
      chk({tbl[k].nm, "_valid"}, out_valid, tbl[k].ev);
      chk({tbl[k].nm, "_A"}, A, tbl[k].ea);
      chk({tbl[k].nm, "_B"}, B, tbl[k].eb);
      chk({tbl[k].nm, "_count"}, count, tbl[k].ec);
      chk({tbl[k].nm, "_busy"}, busy, tbl[k].ebusy);
    end
    wr_valid = 0; start = 0; stop = 0;

    // ---- capacity boundary ----
    do_clear();
    for (int i = 0; i < DEPTH; i++) wr(8'(i * 3 + 1));
    chk("full_count", count, DEPTH);
    chk("full_wr_ready", wr_ready, 0);
    wr(8'd99);
    chk("overflow_count", count, DEPTH);
    out_ready = 1; start = 1; step(); start = 0; step();
    chk("full_first_A", A, 1);
    chk("full_first_B", B, 4);
    repeat (7) step();
    chk("full_last_A", A, 22);
    chk("full_last_B", B, 1);
    stop = 1; step(); stop = 0; step();
    chk("full_idle", busy, 0);

    // ---- start on empty pool ----
    do_clear();
    start = 1; step(); start = 0;
    chk("empty_busy", busy, 0);
    repeat (3) step();
    chk("empty_valid", out_valid, 0);

    // ---- single entry, start+stop together, backpressure hold ----
    do_clear();
    wr(8'd7);
    out_ready = 1; start = 1; stop = 1; step(); start = 0; stop = 0;
    chk("startwins_busy", busy, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("single_valid", out_valid, 1);
      chk("single_A", A, 7);
      chk("single_B", B, 7);
    end
    out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold_valid", out_valid, 1);
      chk("hold_A", A, 7);
      chk("hold_B", B, 7);
    end
    out_ready = 1; stop = 1; step(); stop = 0; step();
    chk("single_stop_busy", busy, 0);

    // ---- stop with pending pair under backpressure ----
    do_clear();
    wr(1); wr(2); wr(3);
    out_ready = 0; start = 1; step(); start = 0; step();
    chk("bp_first_valid", out_valid, 1);
    stop = 1; step(); stop = 0;
    chk("drain_valid", out_valid, 1);
    chk("drain_A", A, 1);
    chk("drain_B", B, 2);
    chk("drain_busy", busy, 1);
    step();
    chk("drain_hold_A", A, 1);
    chk("drain_hold_valid", out_valid, 1);
    out_ready = 1; step();
    chk("drain_done_valid", out_valid, 0);
    chk("drain_done_busy", busy, 0);
    repeat (3) step();
    chk("drain_no_more", out_valid, 0);

    // ---- clear mid-run with simultaneous write ----
    start = 1; step(); start = 0; step();
    chk("pre_clear_valid", out_valid, 1);
    clear = 1; wr_valid = 1; wr_data = 8'd55; #1;
    chk("clear_wr_ready", wr_ready, 0);
    step(); clear = 0; wr_valid = 0;
    chk("clear_valid", out_valid, 0);
    chk("clear_count", count, 0);
    chk("clear_busy", busy, 0);
    step();
    chk("clear_write_dropped", count, 0);

    // ---- asynchronous reset mid-run ----
    wr(4); wr(5);
    start = 1; step(); start = 0; step();
    chk("pre_rst_valid", out_valid, 1);
    #2 rst = 1; #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_A", A, 0);
    chk("arst_B", B, 0);
    chk("arst_count", count, 0);
    chk("arst_busy", busy, 0);
    step(); rst = 0;

    // ---- randomized sequential run against a pool model ----
    begin
      int n0;
      logic rdy, wv;
      logic [7:0] wd;
      do_clear();
      mp.delete(); m_ov = 0; m_run = 0; m_i = 0; m_a = 0; m_b = 0;
      n0 = 2 + int'($urandom % 4);
      for (int i = 0; i < n0; i++) begin
        wd = 8'($urandom);
        wr(wd); mp.push_back(wd);
      end
`ifdef OPERAND_POOL_RANDOM_EN
      mode = 0;
`else
      mode = 1'($urandom % 2);
`endif
      for (int c = 0; c < 400; c++) begin
        int n;
        rdy = 1'($urandom % 2);
        wv  = ($urandom % 12) == 0;
        wd  = 8'($urandom);
        out_ready = rdy; wr_valid = wv; wr_data = wd; start = (c == 0);
        n = mp.size();
        if (m_run) begin
          if (!m_ov || rdy) begin
            m_a = mp[m_i]; m_b = mp[(m_i + 1) % n]; m_ov = 1; m_i = (m_i + 1) % n;
          end
        end else if (start && n != 0) m_run = 1;
        if (wv && n < DEPTH) mp.push_back(wd);
        step();
        chk("rnd_seq_valid", out_valid, m_ov);
        if (m_ov) begin
          chk("rnd_seq_A", A, m_a);
          chk("rnd_seq_B", B, m_b);
        end
        chk("rnd_seq_count", count, mp.size());
      end
      wr_valid = 0; start = 0; mode = 0;
      out_ready = 1; stop = 1; step(); stop = 0;
      begin
        int t = 0;
        while (busy && t < 10) begin step(); t++; end
        chk("rnd_seq_stop_idle", busy, 0);
      end
    end

`ifdef OPERAND_POOL_RANDOM_EN
    // ---- random index mode: membership and cyclic successor ----
    begin
      logic [7:0] rp [5];
      bit seen [5];
      int acc = 0, cyc = 0, distinct = 0;
      do_clear();
      for (int i = 0; i < 5; i++) begin rp[i] = 8'(11 * (i + 1)); wr(rp[i]); seen[i] = 0; end
      mode = 1; out_ready = 0; start = 1; step(); start = 0;
      while (acc < 200 && cyc < 4000) begin
        out_ready = 1'($urandom % 2);
        if (out_valid && out_ready) begin
          int j = -1;
          for (int k = 0; k < 5; k++) if (rp[k] == A) j = k;
          chk("rnd_A_in_pool", (j >= 0), 1);
          if (j >= 0) begin
            chk("rnd_B_successor", B, rp[(j + 1) % 5]);
            seen[j] = 1;
          end
          acc++;
        end
        step(); cyc++;
      end
      chk("rnd_accepted", acc, 200);
      foreach (seen[k]) if (seen[k]) distinct++;
      chk("rnd_distinct_ge4", (distinct >= 4), 1);
      out_ready = 1; stop = 1; step(); stop = 0; step(); mode = 0;
      chk("rnd_stop_idle", busy, 0);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
